// File: rtl/m_wb_arbiter2.sv
// Two-master to one-slave Wishbone B4 classic arbiter.
//
// Master 0 (midgetv core) and master 1 (loader/debug/DMA) share one 32-bit slave. Grants are
// round-robin on contention and held for the whole CYC of the granted master. A watchdog ends
// a strobe that the slave never acknowledges with a one-cycle ERR to the granted master.
//
// Ports:
//   CLK_I, RST_I                   clock, synchronous active-high reset
//   Mx_CYC_I/STB_I/WE_I            master x bus cycle, strobe, write enable
//   Mx_ADR_I/DAT_I/SEL_I           master x address, write data, byte selects
//   Mx_ACK_O, Mx_ERR_O             acknowledge / error back to master x
//   S_CYC_O/STB_O/WE_O/ADR_O/DAT_O/SEL_O  routed slave-side bus
//   S_ACK_I, S_DAT_I               slave acknowledge and read data
//   M_DAT_O                        read data to both masters (S_DAT_I passed through)
//   gnt                            registered one-hot grant, bit0 = master 0, bit1 = master 1
module m_wb_arbiter2 #(
  parameter int unsigned TMO_WIDTH  = 8,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [31:0] M0_DAT_I,
  input  logic [3:0]  M0_SEL_I,
  output logic        M0_ACK_O,
  output logic        M0_ERR_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [31:0] M1_DAT_I,
  input  logic [3:0]  M1_SEL_I,
  output logic        M1_ACK_O,
  output logic        M1_ERR_O,
  output logic        S_CYC_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [31:0] S_ADR_O,
  output logic [31:0] S_DAT_O,
  output logic [3:0]  S_SEL_O,
  input  logic        S_ACK_I,
  input  logic [31:0] S_DAT_I,
  output logic [31:0] M_DAT_O,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

  localparam logic [TMO_WIDTH-1:0] TmoLimit = TMO_WIDTH'(TMO_CYCLES);
  localparam logic [TMO_WIDTH-1:0] CntOne   = TMO_WIDTH'(1);

  state_e               state_q;
  logic                 lastg_q;
  logic [TMO_WIDTH-1:0] cnt_q;

  logic granted;
  logic sel1;
  logic m_cyc;
  logic m_stb;
  logic tmo_fire;

  assign M_DAT_O = S_DAT_I;

  always_comb begin
    // Reset masks routing in the same cycle, so an in-flight slave ACK is never forwarded.
    granted  = (state_q != StIdle) && !RST_I;
    sel1     = (state_q == StG1);
    m_cyc    = sel1 ? M1_CYC_I : M0_CYC_I;
    m_stb    = sel1 ? M1_STB_I : M0_STB_I;
    // ACK on the terminal-count cycle takes precedence over the timeout.
    tmo_fire = granted && m_stb && !S_ACK_I && (cnt_q == TmoLimit);

    S_CYC_O  = granted && m_cyc;
    S_STB_O  = granted && m_stb && !tmo_fire;
    S_WE_O   = granted && (sel1 ? M1_WE_I : M0_WE_I);
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    S_SEL_O  = '0;
    if (granted) begin
      S_ADR_O = sel1 ? M1_ADR_I : M0_ADR_I;
      S_DAT_O = sel1 ? M1_DAT_I : M0_DAT_I;
      S_SEL_O = sel1 ? M1_SEL_I : M0_SEL_I;
    end

    M0_ACK_O = granted && !sel1 && M0_STB_I && S_ACK_I;
    M1_ACK_O = granted &&  sel1 && M1_STB_I && S_ACK_I;
    M0_ERR_O = tmo_fire && !sel1;
    M1_ERR_O = tmo_fire &&  sel1;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= StIdle;
      lastg_q <= 1'b1;
      cnt_q   <= '0;
      gnt     <= 2'b00;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // On a tie the master that was not granted last time wins.
          if (M0_CYC_I && (!M1_CYC_I || lastg_q)) begin
            state_q <= StG0;
            lastg_q <= 1'b0;
            gnt     <= 2'b01;
          end else if (M1_CYC_I) begin
            state_q <= StG1;
            lastg_q <= 1'b1;
            gnt     <= 2'b10;
          end
        end
        StG0, StG1: begin
          if (!m_cyc) begin
            state_q <= StIdle;
            gnt     <= 2'b00;
          end
          // Counting stops at TmoLimit because the fire cycle clears it.
          if (!m_stb || S_ACK_I || tmo_fire) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          gnt     <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_wb_arbiter2.sv
module tb_m_wb_arbiter2;

  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0, s0, w0, c1, s1, w1;
  logic [31:0] a0, d0, a1, d1;
  logic [3:0]  sel0, sel1;
  logic        sack;
  logic [31:0] sdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat, m_dat;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  m_wb_arbiter2 #(
    .TMO_WIDTH (8),
    .TMO_CYCLES(Tmo)
  ) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .M0_CYC_I(c0),
    .M0_STB_I(s0),
    .M0_WE_I (w0),
    .M0_ADR_I(a0),
    .M0_DAT_I(d0),
    .M0_SEL_I(sel0),
    .M0_ACK_O(m0_ack),
    .M0_ERR_O(m0_err),
    .M1_CYC_I(c1),
    .M1_STB_I(s1),
    .M1_WE_I (w1),
    .M1_ADR_I(a1),
    .M1_DAT_I(d1),
    .M1_SEL_I(sel1),
    .M1_ACK_O(m1_ack),
    .M1_ERR_O(m1_err),
    .S_CYC_O (s_cyc),
    .S_STB_O (s_stb),
    .S_WE_O  (s_we),
    .S_ADR_O (s_adr),
    .S_DAT_O (s_dat),
    .S_SEL_O (s_sel),
    .S_ACK_I (sack),
    .S_DAT_I (sdat),
    .M_DAT_O (m_dat),
    .gnt     (gnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    c0 = 0; s0 = 0; w0 = 0; a0 = '0; d0 = '0; sel0 = '0;
    c1 = 0; s1 = 0; w1 = 0; a1 = '0; d1 = '0; sel1 = '0;
    sack = 0; sdat = '0;
  endtask

  // Ends just after a negedge with reset released and the arbiter in IDLE.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // One clock per row: inputs, then the outputs expected during that same cycle.
  typedef struct packed {
    logic       c0, s0, c1, s1, ack;
    logic [1:0] gnt;
    logic       scyc, sstb, a0, e0, a1, e1;
  } vec_t;

  vec_t tbl [20];

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int          own, last, wt;
    logic        cx, sx, fire, act;
    logic [1:0]  eg;
    int          ng;
    logic [1:0]  gp;
    bit          acked;

    rst = 1;
    idle_inputs();

    // Tie from reset, handover, timeout + retry, ACK in IDLE, ACK/terminal-count collision.
    tbl[0]  = '{1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 0, 2'b10, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 0, 2'b10, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 0, 2'b10, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 0, 2'b10, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 1, 0, 2'b10, 1, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 1, 1, 1, 2'b10, 1, 1, 0, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0};
    tbl[14] = '{1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0};
    tbl[15] = '{1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0};
    tbl[16] = '{1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0, 0, 0};
    tbl[17] = '{1, 0, 0, 0, 1, 2'b01, 1, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0};

    do_reset();
    #1;
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_scyc", s_cyc, 0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c0 = tbl[i].c0; s0 = tbl[i].s0; c1 = tbl[i].c1; s1 = tbl[i].s1; sack = tbl[i].ack;
      #1;
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_scyc", i), s_cyc, tbl[i].scyc);
      chk($sformatf("tbl%0d_sstb", i), s_stb, tbl[i].sstb);
      chk($sformatf("tbl%0d_m0ack", i), m0_ack, tbl[i].a0);
      chk($sformatf("tbl%0d_m0err", i), m0_err, tbl[i].e0);
      chk($sformatf("tbl%0d_m1ack", i), m1_ack, tbl[i].a1);
      chk($sformatf("tbl%0d_m1err", i), m1_err, tbl[i].e1);
    end

    // Single M0 read, slave answers two cycles after the strobe.
    do_reset();
    @(negedge clk);
    c0 = 1; s0 = 1; w0 = 0; a0 = 32'h6000_0004; sel0 = 4'hf;
    #1 chk("t1_gnt_req", gnt, 2'b00);
    @(negedge clk);
    #1 chk("t1_gnt", gnt, 2'b01);
    chk("t1_adr", s_adr, 32'h6000_0004);
    chk("t1_sstb", s_stb, 1);
    chk("t1_ack_w1", m0_ack, 0);
    @(negedge clk);
    #1 chk("t1_ack_w2", m0_ack, 0);
    @(negedge clk);
    sack = 1; sdat = 32'hDEAD_BEEF;
    #1 chk("t1_ack", m0_ack, 1);
    chk("t1_rdata", m_dat, 32'hDEAD_BEEF);
    chk("t1_m1ack", m1_ack, 0);
    chk("t1_err", m0_err, 0);
    @(negedge clk);
    sack = 0; c0 = 0; s0 = 0;
    #1 chk("t1_ack_end", m0_ack, 0);
    chk("t1_gnt_hold", gnt, 2'b01);
    chk("t1_scyc_drop", s_cyc, 0);
    @(negedge clk);
    #1 chk("t1_gnt_idle", gnt, 2'b00);
    chk("t1_adr_idle", s_adr, 32'h0);

    // Round robin: both masters re-request, one ACK per grant.
    do_reset();
    ng = 0; gp = 2'b00; acked = 0;
    for (int cy = 0; cy < 60 && ng < 6; cy++) begin
      @(negedge clk);
      if (gnt != 2'b00 && gp == 2'b00) begin
        chk($sformatf("t3_grant%0d", ng), gnt, (ng % 2 == 0) ? 2'b01 : 2'b10);
        ng++;
      end
      gp = gnt;
      c0 = 1; s0 = 1; c1 = 1; s1 = 1; sack = 0;
      if (gnt != 2'b00) begin
        if (!acked) begin
          sack = 1;
          acked = 1;
        end else if (gnt == 2'b01) begin
          c0 = 0; s0 = 0;
        end else begin
          c1 = 0; s1 = 0;
        end
      end else begin
        acked = 0;
      end
    end
    chk("t3_grant_count", ng, 6);

    // Reset mid-burst with a slave ACK in flight, then M1 gets a clean grant and timeout.
    do_reset();
    @(negedge clk);
    c0 = 1; s0 = 1;
    @(negedge clk);
    #1 chk("t6_gnt0", gnt, 2'b01);
    @(negedge clk);
    rst = 1; sack = 1;
    #1 chk("t6_ack_in_rst", m0_ack, 0);
    chk("t6_scyc_in_rst", s_cyc, 0);
    @(negedge clk);
    rst = 0; sack = 0; c0 = 0; s0 = 0; c1 = 1; s1 = 1;
    #1 chk("t6_gnt_after", gnt, 2'b00);
    chk("t6_scyc_after", s_cyc, 0);
    chk("t6_ack_after", m0_ack, 0);
    chk("t6_err_after", m0_err, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk($sformatf("t6_m1_gnt%0d", i), gnt, 2'b10);
      chk($sformatf("t6_m1_stb%0d", i), s_stb, (i < 4) ? 1'b1 : 1'b0);
      chk($sformatf("t6_m1_err%0d", i), m1_err, (i == 4) ? 1'b1 : 1'b0);
    end

    // Random traffic against a behavioural model: owner (-1 none), last owner, wait count.
    do_reset();
    own = -1; last = 1; wt = 0;
    for (int cy = 0; cy < 1500; cy++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) c0 = ~c0;
      if ($urandom_range(0, 7) == 0) c1 = ~c1;
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      w0 = $urandom_range(0, 1); w1 = $urandom_range(0, 1);
      a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
      sel0 = 4'($urandom); sel1 = 4'($urandom);
      sack = ($urandom_range(0, 3) == 0);
      sdat = $urandom;
      #1;
      act  = (own >= 0) && !rst;
      cx   = (own == 1) ? c1 : c0;
      sx   = (own == 1) ? s1 : s0;
      fire = act && sx && !sack && (wt == Tmo);
      eg   = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
      chk("rnd_gnt", gnt, eg);
      chk("rnd_scyc", s_cyc, act && cx);
      chk("rnd_sstb", s_stb, act && sx && !fire);
      chk("rnd_swe", s_we, act && ((own == 1) ? w1 : w0));
      chk("rnd_m0ack", m0_ack, act && own == 0 && sx && sack);
      chk("rnd_m1ack", m1_ack, act && own == 1 && sx && sack);
      chk("rnd_m0err", m0_err, fire && own == 0);
      chk("rnd_m1err", m1_err, fire && own == 1);
      chk("rnd_mdat", m_dat, sdat);
      if (!rst) begin
        chk("rnd_sadr", s_adr, !act ? 32'h0 : (own == 1) ? a1 : a0);
        chk("rnd_sdat", s_dat, !act ? 32'h0 : (own == 1) ? d1 : d0);
        chk("rnd_ssel", s_sel, !act ? 4'h0 : (own == 1) ? sel1 : sel0);
      end
      @(posedge clk);
      if (rst) begin
        own = -1; last = 1; wt = 0;
      end else if (own < 0) begin
        wt = 0;
        if (c0 && (!c1 || last == 1)) own = 0;
        else if (c1) own = 1;
        if (own >= 0) last = own;
      end else if (!cx) begin
        own = -1; wt = 0;
      end else if (!sx || sack || fire) begin
        wt = 0;
      end else begin
        wt++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/m_wb_arbiter2.md
Name: m_wb_arbiter2

Overview:
Two-master to one-slave Wishbone B4 classic arbiter, used to share the 32-bit slave bus between the midgetv core (master 0) and a second master (master 1, a loader/debug or DMA engine). It arbitrates with round-robin priority, holds a grant for the master's whole CYC cycle, and routes strobes and acknowledges. A watchdog ends hung transfers with an error pulse so a missing slave cannot stall either master.

Parameters:
TMO_WIDTH, 8, width of the watchdog counter.
TMO_CYCLES, 255, number of consecutive unacknowledged STB cycles before ERR is issued; legal range 1..2^TMO_WIDTH-1.

Ports:
CLK_I  in  1  system clock; all state updates on the rising edge.
RST_I  in  1  reset; one clock; synchronous, active-high.
M0_CYC_I, M0_STB_I, M0_WE_I  in  1 each  master 0 bus cycle, strobe and write enable.
M0_ADR_I  in  32  master 0 address.
M0_DAT_I  in  32  master 0 write data.
M0_SEL_I  in  4  master 0 byte selects.
M0_ACK_O, M0_ERR_O  out  1 each  acknowledge and error to master 0.
M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I, M1_SEL_I  in  as M0  master 1 bus signals.
M1_ACK_O, M1_ERR_O  out  1 each  acknowledge and error to master 1.
S_CYC_O, S_STB_O, S_WE_O  out  1 each  slave-side bus cycle, strobe and write enable.
S_ADR_O  out  32  slave-side address.
S_DAT_O  out  32  slave-side write data.
S_SEL_O  out  4  slave-side byte selects.
S_ACK_I  in  1  slave acknowledge.
S_DAT_I  in  32  slave read data.
M_DAT_O  out  32  read data to both masters; equals S_DAT_I with no gating.
gnt  out  2  one-hot grant status; bit0 = master 0, bit1 = master 1.

Behaviour:
- Registered state machine with states IDLE, G0, G1. There is also a registered last-granted bit, lastg.
- Reset state: IDLE, lastg=1 (master 0 wins the first tie), watchdog counter=0. gnt=00.
- While reset is active or the arbiter is in IDLE, all S_CYC_O, S_STB_O, S_WE_O, Mx_ACK_O and Mx_ERR_O outputs are 0.
- IDLE transitions:
  - Only M0_CYC_I high: go to G0.
  - Only M1_CYC_I high: go to G1.
  - Both high: grant the master that is not lastg.
  - Neither high: stay in IDLE.
  - Arbitration latency is one clock: a request at edge n produces a grant visible after edge n+1.
- Entering Gx sets lastg=x.
- Gx to IDLE: on the edge where Mx_CYC_I is sampled low. There is one dead IDLE cycle between grants, so a handover to the other master takes at least 2 clocks.
- Routing in Gx is combinational from the state register:
  - S_CYC_O=Mx_CYC_I.
  - S_STB_O=Mx_STB_I & ~tmo_fire.
  - S_WE_O, S_ADR_O, S_DAT_O and S_SEL_O come from master x.
  - In IDLE, the address, data and select outputs are 0.
- Acknowledge and error routing:
  - Mx_ACK_O=S_ACK_I & Mx_STB_I, only while in Gx. The non-granted master never sees ACK or ERR.
  - A slave ACK arriving while STB is low, or while in IDLE, is discarded.
- Watchdog:
  - The counter increments each cycle that the granted master has STB high and S_ACK_I is low.
  - It clears on S_ACK_I, on STB low, in IDLE, and on reset.
  - tmo_fire = (count == TMO_CYCLES) & STB & ~S_ACK_I.
  - On tmo_fire: Mx_ERR_O=1 for that cycle, S_STB_O is forced to 0, and the counter clears at the next edge.
  - If S_ACK_I and a terminal count coincide, ACK wins and ERR stays 0.
  - ACK and ERR are never both high.
- Width handling: the counter is TMO_WIDTH bits and does not wrap, because it clears at TMO_CYCLES.
- Pipelined bursts: a master may hold CYC across many STB/ACK pairs; the grant persists throughout.
- Reset during a transfer: at the next edge the state is IDLE, S_CYC_O=0, and no ACK/ERR is emitted. An in-flight slave ACK is dropped.
- Master drops CYC mid-transfer: S_CYC_O follows combinationally in the same cycle, and the state returns to IDLE on the next edge.

Test Plan:
1. M0 single read: M0 CYC/STB with ADR=0x60000004, slave ACKs 2 cycles after strobe with S_DAT_I=0xDEADBEEF -> gnt=01 one clock after request; M0_ACK_O pulses 1 cycle; M_DAT_O=0xDEADBEEF; M1_ACK_O stays 0; state returns to IDLE one clock after CYC drops.
2. Simultaneous requests from reset: both CYC high at the same edge -> M0 granted first. Master 1 is then held off and sees S_CYC_O driven by M0 only. After M0 releases, one IDLE cycle, then gnt=10.
3. Round-robin fairness: both masters re-request continuously for 6 transfers of one ACK each -> the grant sequence is 0,1,0,1,0,1 with no master granted twice in a row.
4. Timeout: TMO_CYCLES=4, M1 strobes with no slave ACK -> S_STB_O is high for 4 cycles. M1_ERR_O pulses on the 5th cycle with S_STB_O=0 in that cycle. The counter then restarts, and a retried STB is ACKed normally.
5. ACK/timeout collision: S_ACK_I asserted exactly on the terminal count cycle -> M0_ACK_O=1, M0_ERR_O=0.
6. Reset mid-burst: M0 in G0 with STB high; assert RST_I for 1 clock while the slave asserts ACK -> M0_ACK_O=0 after the edge. The outputs show state IDLE, gnt=00, S_CYC_O=0 and counter=0, and the next request from M1 is granted normally.
